// File: rtl/iob_eth_pkg.sv
// Shared Ethernet TX definitions: CRC-32 constants, framer state encoding and
// the bytewise MSB-first CRC update used by the FCS datapath.
package iob_eth_pkg;

  localparam logic [31:0] ETH_CRC_POLY    = 32'h04C11DB7;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam int          ETH_MIN_PAYLOAD = 60;

  typedef enum logic [1:0] {
    ST_DATA = 2'd0,
    ST_PAD  = 2'd1,
    ST_FCS  = 2'd2
  } eth_fcs_state_e;

  // Eight serial shift steps of the MSB-first CRC, data bit 7 first.
  function automatic logic [31:0] eth_crc32_update(input logic [31:0] crc,
                                                   input logic [7:0]  data);
    logic [31:0] c;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      if (c[31] ^ data[i]) begin
        c = {c[30:0], 1'b0} ^ ETH_CRC_POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/iob_eth_crc32_byte.sv
// Combinational one-byte CRC-32 update; data_i is expected already bit-reversed.
module iob_eth_crc32_byte
  import iob_eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  assign crc_o = eth_crc32_update(crc_i, data_i);

endmodule

// File: rtl/iob_reverse.sv
// Bit-order reversal of a DATA_W-bit vector (pure wiring).
module iob_reverse #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o
);

  for (genvar i = 0; i < DATA_W; i++) begin : g_rev
    assign data_o[i] = data_i[DATA_W-1-i];
  end

endmodule

// File: rtl/iob_eth_fcs_append.sv
// Ethernet TX framer stage: passes payload through, zero-pads to MIN_LEN and
// appends the 4-byte FCS, with a single registered output stage.
module iob_eth_fcs_append
  import iob_eth_pkg::*;
#(
  parameter int MIN_LEN = ETH_MIN_PAYLOAD,
  parameter int CNT_W   = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] in_data_i,
  input  logic       in_valid_i,
  input  logic       in_last_i,
  output logic       in_ready_o,
  output logic [7:0] out_data_o,
  output logic       out_valid_o,
  output logic       out_last_o,
  input  logic       out_ready_i
);

  localparam logic [CNT_W:0] MIN_LEN_C = (CNT_W+1)'(MIN_LEN);

  eth_fcs_state_e   r_state, w_state_nxt;
  logic [31:0]      r_crc, w_crc_nxt, w_crc_upd, w_crc_rev, w_fcs;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [CNT_W:0]   w_cnt_inc, w_cnt_inc2;
  logic [1:0]       r_fcs_idx, w_fcs_idx_nxt;
  logic [7:0]       r_out_data, w_out_data_nxt;
  logic             r_out_valid, w_out_valid_nxt;
  logic             r_out_last, w_out_last_nxt;
  logic [7:0]       w_crc_byte, w_crc_byte_rev, w_fcs_byte;
  logic             w_ld, w_xfer;

  assign w_ld       = !r_out_valid || out_ready_i;
  assign in_ready_o = (r_state == ST_DATA) && w_ld;
  assign w_xfer     = in_valid_i && in_ready_o;

  // count+2 <= MIN_LEN is the same test as count+1 < MIN_LEN without a
  // degenerate compare against zero when padding is disabled.
  assign w_cnt_inc  = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_cnt_inc2 = {1'b0, r_cnt} + {{(CNT_W-1){1'b0}}, 2'd2};

  assign w_crc_byte = (r_state == ST_DATA) ? in_data_i : 8'h00;

  iob_reverse #(.DATA_W(8)) u_rev_data (
    .data_i (w_crc_byte),
    .data_o (w_crc_byte_rev)
  );

  iob_eth_crc32_byte u_crc (
    .crc_i  (r_crc),
    .data_i (w_crc_byte_rev),
    .crc_o  (w_crc_upd)
  );

  iob_reverse #(.DATA_W(32)) u_rev_crc (
    .data_i (r_crc),
    .data_o (w_crc_rev)
  );

  assign w_fcs = ~w_crc_rev;

  // FCS byte selection, least significant byte first on the wire.
  always_comb begin
    w_fcs_byte = 8'h00;
    case (r_fcs_idx)
      2'd0:    w_fcs_byte = w_fcs[7:0];
      2'd1:    w_fcs_byte = w_fcs[15:8];
      2'd2:    w_fcs_byte = w_fcs[23:16];
      2'd3:    w_fcs_byte = w_fcs[31:24];
      default: w_fcs_byte = 8'h00;
    endcase
  end

  // Next-state, CRC, counter and output-register values.
  always_comb begin
    w_state_nxt     = r_state;
    w_crc_nxt       = r_crc;
    w_cnt_nxt       = r_cnt;
    w_fcs_idx_nxt   = r_fcs_idx;
    w_out_data_nxt  = r_out_data;
    w_out_valid_nxt = r_out_valid;
    w_out_last_nxt  = r_out_last;
    if (w_ld) begin
      case (r_state)
        ST_DATA: begin
          if (w_xfer) begin
            w_out_data_nxt  = in_data_i;
            w_out_valid_nxt = 1'b1;
            w_out_last_nxt  = 1'b0;
            w_crc_nxt       = w_crc_upd;
            w_cnt_nxt       = (w_cnt_inc <= MIN_LEN_C) ? w_cnt_inc[CNT_W-1:0] : r_cnt;
            if (in_last_i) begin
              w_state_nxt = (w_cnt_inc2 <= MIN_LEN_C) ? ST_PAD : ST_FCS;
            end else begin
              w_state_nxt = ST_DATA;
            end
          end else begin
            w_out_valid_nxt = 1'b0;
            w_out_last_nxt  = 1'b0;
          end
        end
        ST_PAD: begin
          w_out_data_nxt  = 8'h00;
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = 1'b0;
          w_crc_nxt       = w_crc_upd;
          w_cnt_nxt       = w_cnt_inc[CNT_W-1:0];
          w_state_nxt     = (w_cnt_inc == MIN_LEN_C) ? ST_FCS : ST_PAD;
        end
        ST_FCS: begin
          w_out_data_nxt  = w_fcs_byte;
          w_out_valid_nxt = 1'b1;
          w_out_last_nxt  = (r_fcs_idx == 2'd3);
          if (r_fcs_idx == 2'd3) begin
            w_crc_nxt     = ETH_CRC_INIT;
            w_cnt_nxt     = {CNT_W{1'b0}};
            w_fcs_idx_nxt = 2'd0;
            w_state_nxt   = ST_DATA;
          end else begin
            w_fcs_idx_nxt = r_fcs_idx + 2'd1;
          end
        end
        default: begin
          w_state_nxt     = ST_DATA;
          w_out_valid_nxt = 1'b0;
          w_out_last_nxt  = 1'b0;
        end
      endcase
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, CRC, counter and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_DATA;
      r_crc       <= ETH_CRC_INIT;
      r_cnt       <= {CNT_W{1'b0}};
      r_fcs_idx   <= 2'd0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_crc       <= w_crc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fcs_idx   <= w_fcs_idx_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  assign out_data_o  = r_out_data;
  assign out_valid_o = r_out_valid;
  assign out_last_o  = r_out_last;

endmodule

// File: tb/tb_iob_eth_fcs_append.sv
// Directed bench for iob_eth_fcs_append with MIN_LEN=0 and MIN_LEN=60 instances.
module tb_iob_eth_fcs_append;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel;
  logic [7:0] in_data;
  logic       in_valid, in_last, out_ready;
  logic       in_ready, out_valid, out_last;
  logic [7:0] out_data;

  logic       v0, r0, ir0, ov0, ol0;
  logic       v1, r1, ir1, ov1, ol1;
  logic [7:0] od0, od1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tx_data[$];
  logic       tx_last[$];
  logic [7:0] exp_data[$];
  logic       exp_last[$];
  int         run_low;
  int         run_gaps;

  always #5 clk = ~clk;

  assign v0 = !sel && in_valid;
  assign r0 = !sel && out_ready;
  assign v1 = sel && in_valid;
  assign r1 = sel && out_ready;
  assign in_ready  = sel ? ir1 : ir0;
  assign out_valid = sel ? ov1 : ov0;
  assign out_last  = sel ? ol1 : ol0;
  assign out_data  = sel ? od1 : od0;

  iob_eth_fcs_append #(.MIN_LEN(0), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(v0),
    .in_last_i(in_last), .in_ready_o(ir0), .out_data_o(od0),
    .out_valid_o(ov0), .out_last_o(ol0), .out_ready_i(r0));

  iob_eth_fcs_append #(.MIN_LEN(60), .CNT_W(16)) dut60 (
    .clk_i(clk), .rst_i(rst), .in_data_i(in_data), .in_valid_i(v1),
    .in_last_i(in_last), .in_ready_o(ir1), .out_data_o(od1),
    .out_valid_o(ov1), .out_last_o(ol1), .out_ready_i(r1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Reflected LSB-first software CRC-32, returns the FCS value.
  function automatic logic [31:0] ref_fcs(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h000000, q[i]};
      for (int b = 0; b < 8; b++) begin
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
    end
    return ~c;
  endfunction

  task automatic add_frame(input logic [7:0] pl[$], input int min_len, input bit fixed_fcs);
    logic [7:0]  q[$];
    logic [31:0] f;
    foreach (pl[i]) begin
      tx_data.push_back(pl[i]);
      tx_last.push_back(i == pl.size() - 1);
      q.push_back(pl[i]);
    end
    for (int i = pl.size(); i < min_len; i++) q.push_back(8'h00);
    foreach (q[i]) begin
      exp_data.push_back(q[i]);
      exp_last.push_back(1'b0);
    end
    f = fixed_fcs ? 32'hCBF43926 : ref_fcs(q);
    for (int i = 0; i < 4; i++) begin
      exp_data.push_back(f[8*i +: 8]);
      exp_last.push_back(i == 3);
    end
  endtask

  task automatic run(input bit rnd, input int budget, input string tag);
    int  cyc = 0;
    int  ti = 0;
    int  ei = 0;
    bit  stalled = 1'b0;
    bit  counting = 1'b0;
    bit  started = 1'b0;
    bit  low_done = 1'b0;
    logic [7:0] hd = 8'h00;
    logic       hl = 1'b0;
    run_low  = -1;
    run_gaps = 0;
    while (ei < exp_data.size() && cyc < budget) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ti < tx_data.size()) begin
        in_valid = 1'b1; in_data = tx_data[ti]; in_last = tx_last[ti];
      end else begin
        in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
      end
      #1;
      if (stalled) begin
        check({tag, ".hold_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".hold_data"}, {24'd0, out_data}, {24'd0, hd});
        check({tag, ".hold_last"}, {31'd0, out_last}, {31'd0, hl});
      end
      if (out_valid && !out_ready)
        check({tag, ".stall_ready"}, {31'd0, in_ready}, 32'd0);
      if (counting) begin
        if (!in_ready) begin
          run_low++;
        end else begin
          counting = 1'b0;
          low_done = 1'b1;
        end
      end
      if (in_valid && in_ready) begin
        if (in_last && !low_done && !counting) begin
          counting = 1'b1;
          run_low  = 0;
        end
        ti++;
      end
      if (out_valid && out_ready) begin
        check({tag, ".data"}, {24'd0, out_data}, {24'd0, exp_data[ei]});
        check({tag, ".last"}, {31'd0, out_last}, {31'd0, exp_last[ei]});
        ei++;
        started = 1'b1;
      end else if (started && !out_valid) begin
        run_gaps++;
      end
      stalled = out_valid && !out_ready;
      hd = out_data;
      hl = out_last;
      cyc++;
    end
    if (ei < exp_data.size()) check({tag, ".timeout"}, ei, exp_data.size());
    tx_data.delete(); tx_last.delete(); exp_data.delete(); exp_last.delete();
  endtask

  initial begin
    logic [7:0] s9[$];
    logic [7:0] one[$];
    logic [7:0] f55[$];
    for (int i = 0; i < 9; i++) s9.push_back(8'h31 + 8'(i));
    one.push_back(8'hAB);
    for (int i = 0; i < 60; i++) f55.push_back(8'h55);

    rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    in_last = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst0.valid", {31'd0, out_valid}, 32'd0);
    check("rst0.last",  {31'd0, out_last},  32'd0);
    check("rst0.data",  {24'd0, out_data},  32'd0);
    check("rst0.ready", {31'd0, in_ready},  32'd1);
    sel = 1'b1;
    #1;
    check("rst60.valid", {31'd0, out_valid}, 32'd0);
    check("rst60.data",  {24'd0, out_data},  32'd0);
    check("rst60.ready", {31'd0, in_ready},  32'd1);
    rst = 1'b0;
    sel = 1'b0;

    // MIN_LEN=0, check value frame, contiguous
    add_frame(s9, 0, 1'b1);
    run(1'b0, 200, "crc9");
    check("crc9.gaps", run_gaps, 0);
    check("crc9.rdy_low", run_low, 4);

    // MIN_LEN=60, single byte padded frame
    sel = 1'b1;
    add_frame(one, 60, 1'b0);
    run(1'b0, 300, "pad1");
    check("pad1.gaps", run_gaps, 0);
    check("pad1.rdy_low", run_low, 63);

    // random backpressure, MIN_LEN=0
    sel = 1'b0;
    add_frame(s9, 0, 1'b1);
    run(1'b1, 400, "stall9");

    // back-to-back frames, MIN_LEN=60
    sel = 1'b1;
    add_frame(s9, 60, 1'b0);
    add_frame(f55, 60, 1'b0);
    run(1'b0, 500, "b2b");
    check("b2b.gaps", run_gaps, 0);
    check("b2b.rdy_low", run_low, 55);

    // check value with pad under MIN_LEN=60 stays model-consistent, random stall
    add_frame(s9, 60, 1'b0);
    run(1'b1, 600, "stall60");

    // mid-frame reset on MIN_LEN=0 instance
    sel = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tx_data.push_back(s9[i]); tx_last.push_back(1'b0);
      exp_data.push_back(s9[i]); exp_last.push_back(1'b0);
    end
    run(1'b0, 100, "abort");
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("mrst.valid", {31'd0, out_valid}, 32'd0);
    check("mrst.last",  {31'd0, out_last},  32'd0);
    check("mrst.data",  {24'd0, out_data},  32'd0);
    check("mrst.ready", {31'd0, in_ready},  32'd1);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("mrst.idle", {31'd0, out_valid}, 32'd0);
    add_frame(s9, 0, 1'b1);
    run(1'b0, 200, "after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
